// File: rtl/arc_pkg.sv
// Shared definitions for the ARC pipeline writeback stage:
// load-format encodings, writeback FSM states and the W pipeline register.
package arc_pkg;

  localparam logic [1:0] LD_W  = 2'b00;
  localparam logic [1:0] LD_H  = 2'b01;
  localparam logic [1:0] LD_B  = 2'b10;
  localparam logic [1:0] LD_BU = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  // Everything the W stage keeps from the memory stage.
  typedef struct packed {
    logic        vld;
    logic        regwrite;
    logic        memtoreg;
    logic        alupc8;
    logic [1:0]  loadmux;
    logic [31:0] alures;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } w_reg_t;

endpackage

// File: rtl/W_load_align.sv
// Big-endian load alignment: picks the half/byte addressed by the offset
// out of the read word and sign- or zero-extends it to 32 bits.
module W_load_align
  import arc_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_loadmux,
  output logic [31:0] o_data
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  // Select the addressed lane, then extend according to the load format.
  always_comb begin
    half     = i_offset[1] ? i_word[15:0] : i_word[31:16];
    byte_sel = i_word[31:24];
    case (i_offset)
      2'd0:    byte_sel = i_word[31:24];
      2'd1:    byte_sel = i_word[23:16];
      2'd2:    byte_sel = i_word[15:8];
      default: byte_sel = i_word[7:0];
    endcase
    case (i_loadmux)
      LD_W:    o_data = i_word;
      LD_H:    o_data = {{16{half[15]}}, half};
      LD_B:    o_data = {{24{byte_sel[7]}}, byte_sel};
      default: o_data = {24'h0, byte_sel};
    endcase
  end

endmodule

// File: rtl/writeback.sv
// W stage of the ARC five-stage pipeline: holds the memory-stage result,
// waits for load data (stalling the pipe), and drives the register-bank
// write port. A load that never gets a response is dropped after
// TIMEOUT_CYC stall cycles and raises a sticky error.
// Optional feature macro: WB_RETIRE_CNT_EN adds a retired-instruction count.
module writeback
  import arc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_con_Mregwrite,
  input  logic        i_con_Mmemtoreg,
  input  logic        i_con_Malupc8,
  input  logic [1:0]  i_con_Mloadmux,
  input  logic [31:0] i_data_alures,
  input  logic [31:0] i_addr_pc4,
  input  logic [4:0]  i_addr_rd,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_data_memrd,
  output logic        o_con_Wregwrite,
  output logic [4:0]  o_addr_Wregwrite,
  output logic [31:0] o_data_Wregwrite,
  output logic        o_con_stall,
`ifdef WB_RETIRE_CNT_EN
  output logic        o_err_timeout,
  output logic [31:0] o_data_retired
`else
  output logic        o_err_timeout
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

  w_reg_t          w_q, w_d;
  wb_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
  logic            ld_pend, timeout, stall, retire;
  logic [31:0]     ld_data;

  W_load_align u_align (
    .i_word    (i_data_memrd),
    .i_offset  (w_q.alures[1:0]),
    .i_loadmux (w_q.loadmux),
    .o_data    (ld_data)
  );

  // Stall/timeout decode, W capture, FSM next state and write-port outputs.
  always_comb begin
    ld_pend = w_q.vld & w_q.memtoreg;
    cnt_inc = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
    // The timeout cycle is the one in which the counter reaches TMO;
    // a response in that same cycle still wins.
    timeout = (state_q == WAIT) & ld_pend & ~i_mem_rvalid & (cnt_inc >= TMO);
    stall   = ld_pend & ~i_mem_rvalid & ~timeout;
    // Anything valid that leaves W retires, except a dropped load.
    retire  = w_q.vld & ~(ld_pend & ~i_mem_rvalid);

    w_d = w_q;
    if (!stall) begin
      w_d.vld      = i_valid;
      w_d.regwrite = i_con_Mregwrite;
      w_d.memtoreg = i_con_Mmemtoreg;
      w_d.alupc8   = i_con_Malupc8;
      w_d.loadmux  = i_con_Mloadmux;
      w_d.alures   = i_data_alures;
      w_d.pc4      = i_addr_pc4;
      w_d.rd       = i_addr_rd;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        cnt_d = '0;
        if (ld_pend && !i_mem_rvalid) state_d = WAIT;
      end
      default: begin
        if (!ld_pend || i_mem_rvalid) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = RUN;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase

    o_con_stall      = stall;
    o_addr_Wregwrite = w_q.rd;
    o_data_Wregwrite = w_q.alupc8   ? w_q.pc4 + 32'd4 :
                       w_q.memtoreg ? ld_data : w_q.alures;
    o_con_Wregwrite  = w_q.vld & w_q.regwrite & (w_q.rd != 5'd0) &
                       (~w_q.memtoreg | i_mem_rvalid);
    o_err_timeout    = err_q;
  end

  // W register, FSM state, wait counter and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_q     <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      w_q     <= w_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] ret_q, ret_d;

  // Count instructions leaving W; wraps modulo 2^32.
  always_comb begin
    ret_d = ret_q + {31'h0, retire};
  end

  // Retired-instruction counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) ret_q <= '0;
    else       ret_q <= ret_d;
  end

  assign o_data_retired = ret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage (TIMEOUT_CYC overridden to 8).
module tb_writeback;
  import arc_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, i_con_Mregwrite = 1'b0, i_con_Mmemtoreg = 1'b0, i_con_Malupc8 = 1'b0;
  logic [1:0]  i_con_Mloadmux = 2'b00;
  logic [31:0] i_data_alures = '0, i_addr_pc4 = '0, i_data_memrd = '0;
  logic [4:0]  i_addr_rd = '0;
  logic        i_mem_rvalid = 1'b0;
  logic        o_con_Wregwrite, o_con_stall, o_err_timeout;
  logic [4:0]  o_addr_Wregwrite;
  logic [31:0] o_data_Wregwrite;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] o_data_retired;
`endif

  int errs = 0;
  int checks = 0;

  writeback #(.TIMEOUT_CYC(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
    .i_con_Mregwrite(i_con_Mregwrite), .i_con_Mmemtoreg(i_con_Mmemtoreg),
    .i_con_Malupc8(i_con_Malupc8), .i_con_Mloadmux(i_con_Mloadmux),
    .i_data_alures(i_data_alures), .i_addr_pc4(i_addr_pc4), .i_addr_rd(i_addr_rd),
    .i_mem_rvalid(i_mem_rvalid), .i_data_memrd(i_data_memrd),
    .o_con_Wregwrite(o_con_Wregwrite), .o_addr_Wregwrite(o_addr_Wregwrite),
    .o_data_Wregwrite(o_data_Wregwrite), .o_con_stall(o_con_stall),
`ifdef WB_RETIRE_CNT_EN
    .o_err_timeout(o_err_timeout), .o_data_retired(o_data_retired)
`else
    .o_err_timeout(o_err_timeout)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic rw, input logic m2r, input logic pc8,
                        input logic [1:0] mux, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [4:0] rd);
    i_valid = v; i_con_Mregwrite = rw; i_con_Mmemtoreg = m2r; i_con_Malupc8 = pc8;
    i_con_Mloadmux = mux; i_data_alures = alu; i_addr_pc4 = pc4; i_addr_rd = rd;
  endtask

  task automatic bubble();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, LD_W, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; bubble(); i_mem_rvalid = 1'b0;
    step();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; bubble(); i_mem_rvalid = 1'b0;
    step(); step();
    i_rst = 1'b0;
    #1;
    checks++; if (o_con_Wregwrite !== 1'b0) begin errs++; $display("FAIL reset_we got %b exp 0", o_con_Wregwrite); end
    checks++; if (o_addr_Wregwrite !== 5'd0) begin errs++; $display("FAIL reset_addr got %0d exp 0", o_addr_Wregwrite); end
    checks++; if (o_data_Wregwrite !== 32'h0) begin errs++; $display("FAIL reset_data got %h exp 0", o_data_Wregwrite); end
    checks++; if (o_con_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b exp 0", o_con_stall); end
    checks++; if (o_err_timeout !== 1'b0) begin errs++; $display("FAIL reset_err got %b exp 0", o_err_timeout); end
`ifdef WB_RETIRE_CNT_EN
    checks++; if (o_data_retired !== 32'h0) begin errs++; $display("FAIL reset_retired got %0d exp 0", o_data_retired); end
`endif
  endtask

  task automatic test_alu();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, LD_W, 32'h1234_5678, 32'h0, 5'd5);
    step(); bubble(); #1;
    checks++; if (o_con_Wregwrite !== 1'b1) begin errs++; $display("FAIL alu_we got %b exp 1", o_con_Wregwrite); end
    checks++; if (o_addr_Wregwrite !== 5'd5) begin errs++; $display("FAIL alu_addr got %0d exp 5", o_addr_Wregwrite); end
    checks++; if (o_data_Wregwrite !== 32'h1234_5678) begin errs++; $display("FAIL alu_data got %h exp 12345678", o_data_Wregwrite); end
    checks++; if (o_con_stall !== 1'b0) begin errs++; $display("FAIL alu_stall got %b exp 0", o_con_stall); end
    step();
    checks++; if (o_con_Wregwrite !== 1'b0) begin errs++; $display("FAIL alu_bubble_we got %b exp 0", o_con_Wregwrite); end
  endtask

  task automatic test_load_align();
    logic [1:0]  mux [6] = '{LD_B, LD_BU, LD_H, LD_H, LD_BU, LD_W};
    logic [1:0]  off [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1};
    logic [31:0] rd  [6] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001,
                             32'h7FFF_0000, 32'hA500_0000, 32'hDEAD_BEEF};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                             32'h0000_7FFF, 32'h0000_00A5, 32'hDEAD_BEEF};
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0, mux[i], {30'h40, off[i]}, 32'h0, 5'd8);
      step(); bubble();
      i_mem_rvalid = 1'b1; i_data_memrd = rd[i];
      #1;
      checks++; if (o_con_Wregwrite !== 1'b1 || o_addr_Wregwrite !== 5'd8) begin
        errs++; $display("FAIL ld%0d_we got we=%b rd=%0d exp we=1 rd=8", i, o_con_Wregwrite, o_addr_Wregwrite); end
      checks++; if (o_data_Wregwrite !== exp[i]) begin
        errs++; $display("FAIL ld%0d_data got %h exp %h", i, o_data_Wregwrite, exp[i]); end
      checks++; if (o_con_stall !== 1'b0) begin errs++; $display("FAIL ld%0d_stall got %b exp 0", i, o_con_stall); end
      step();
      i_mem_rvalid = 1'b0;
    end
  endtask

  task automatic test_load_delay();
    int nstall = 0;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, LD_W, 32'h0000_0100, 32'h0, 5'd8);
    step();
    // Upstream presents the next instruction; it must not enter W yet.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, LD_W, 32'hDEAD_0009, 32'h0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      if (o_con_stall === 1'b1 && o_con_Wregwrite === 1'b0 && o_addr_Wregwrite === 5'd8) nstall++;
      step();
    end
    checks++; if (nstall != 4) begin errs++; $display("FAIL dly_stall_cycles got %0d exp 4", nstall); end
    i_mem_rvalid = 1'b1; i_data_memrd = 32'hCAFE_BABE;
    #1;
    checks++; if (o_con_stall !== 1'b0) begin errs++; $display("FAIL dly_stall_rv got %b exp 0", o_con_stall); end
    checks++; if (o_con_Wregwrite !== 1'b1 || o_addr_Wregwrite !== 5'd8 || o_data_Wregwrite !== 32'hCAFE_BABE) begin
      errs++; $display("FAIL dly_commit got we=%b rd=%0d d=%h exp we=1 rd=8 d=cafebabe",
                       o_con_Wregwrite, o_addr_Wregwrite, o_data_Wregwrite); end
    step();
    i_mem_rvalid = 1'b0; bubble();
    #1;
    checks++; if (o_con_Wregwrite !== 1'b1 || o_addr_Wregwrite !== 5'd9 || o_data_Wregwrite !== 32'hDEAD_0009) begin
      errs++; $display("FAIL dly_next got we=%b rd=%0d d=%h exp we=1 rd=9 d=dead0009",
                       o_con_Wregwrite, o_addr_Wregwrite, o_data_Wregwrite); end
    step();
  endtask

  task automatic test_jal_r0();
    set_in(1'b1, 1'b1, 1'b0, 1'b1, LD_W, 32'h0, 32'h0040_0008, 5'd31);
    step();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, LD_W, 32'h0000_0055, 32'h0, 5'd0);
    #1;
    checks++; if (o_con_Wregwrite !== 1'b1 || o_addr_Wregwrite !== 5'd31 || o_data_Wregwrite !== 32'h0040_000C) begin
      errs++; $display("FAIL jal got we=%b rd=%0d d=%h exp we=1 rd=31 d=0040000c",
                       o_con_Wregwrite, o_addr_Wregwrite, o_data_Wregwrite); end
    step(); bubble(); #1;
    checks++; if (o_con_Wregwrite !== 1'b0) begin errs++; $display("FAIL r0_we got %b exp 0", o_con_Wregwrite); end
    step();
  endtask

  task automatic test_timeout();
    int nstall = 0;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, LD_W, 32'h0, 32'h0, 5'd10);
    step(); bubble();
    for (int i = 0; i < 8; i++) begin
      if (o_con_stall === 1'b1 && o_con_Wregwrite === 1'b0) nstall++;
      step();
    end
    checks++; if (nstall != 8) begin errs++; $display("FAIL tmo_stall_cycles got %0d exp 8", nstall); end
    checks++; if (o_con_stall !== 1'b0 || o_con_Wregwrite !== 1'b0) begin
      errs++; $display("FAIL tmo_cycle got stall=%b we=%b exp stall=0 we=0", o_con_stall, o_con_Wregwrite); end
    step();
    checks++; if (o_err_timeout !== 1'b1) begin errs++; $display("FAIL tmo_err got %b exp 1", o_err_timeout); end
    step(); step();
    checks++; if (o_err_timeout !== 1'b1 || o_con_stall !== 1'b0) begin
      errs++; $display("FAIL tmo_sticky got err=%b stall=%b exp err=1 stall=0", o_err_timeout, o_con_stall); end
  endtask

  task automatic test_timeout_rvalid();
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, LD_W, 32'h0, 32'h0, 5'd11);
    step(); bubble();
    for (int i = 0; i < 8; i++) step();
    i_mem_rvalid = 1'b1; i_data_memrd = 32'h1357_9BDF;
    #1;
    checks++; if (o_con_Wregwrite !== 1'b1 || o_addr_Wregwrite !== 5'd11 || o_data_Wregwrite !== 32'h1357_9BDF) begin
      errs++; $display("FAIL tmorv_commit got we=%b rd=%0d d=%h exp we=1 rd=11 d=13579bdf",
                       o_con_Wregwrite, o_addr_Wregwrite, o_data_Wregwrite); end
    step();
    i_mem_rvalid = 1'b0; #1;
    checks++; if (o_err_timeout !== 1'b0 || o_con_stall !== 1'b0) begin
      errs++; $display("FAIL tmorv_err got err=%b stall=%b exp 0 0", o_err_timeout, o_con_stall); end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, LD_W, 32'h1, 32'h0, 5'd5); step();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, LD_W, 32'h2, 32'h0, 5'd0); step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, LD_W, 32'h3, 32'h0, 5'd7); step();
    bubble(); step(); step();
    checks++; if (o_data_retired !== 32'd3) begin errs++; $display("FAIL retire_cnt got %0d exp 3", o_data_retired); end
    set_in(1'b1, 1'b1, 1'b1, 1'b0, LD_W, 32'h0, 32'h0, 5'd4); step();
    bubble();
    for (int i = 0; i < 10; i++) step();
    checks++; if (o_data_retired !== 32'd3) begin errs++; $display("FAIL retire_drop got %0d exp 3", o_data_retired); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, LD_W, 32'h1, 32'h0, 5'd3); step();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, LD_W, 32'h0, 32'h0, 5'd4); step();
    bubble(); step(); step();
    checks++; if (o_con_stall !== 1'b1) begin errs++; $display("FAIL mid_wait_stall got %b exp 1", o_con_stall); end
    i_rst = 1'b1; step(); i_rst = 1'b0; #1;
    checks++; if (o_con_stall !== 1'b0 || o_err_timeout !== 1'b0 || o_con_Wregwrite !== 1'b0) begin
      errs++; $display("FAIL mid_wait_rst got stall=%b err=%b we=%b exp 0 0 0",
                       o_con_stall, o_err_timeout, o_con_Wregwrite); end
`ifdef WB_RETIRE_CNT_EN
    checks++; if (o_data_retired !== 32'd0) begin errs++; $display("FAIL mid_wait_retired got %0d exp 0", o_data_retired); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_align();
    test_load_delay();
    test_jal_r0();
    test_timeout();
    test_timeout_rvalid();
`ifdef WB_RETIRE_CNT_EN
    test_retire();
`endif
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1);
  end

endmodule
